// File: rtl/d_ff.sv
// d_ff: parameterizable D-type register.
// It has an asynchronous active-low reset, a synchronous clear and a load enable.
// It also provides a complementary output and a one-cycle "value changed" flag.
// Clear has priority over enable. Deassertion of rst_n is not synchronized here.
module d_ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0] CLEAR_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             changed
);

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic             changed_reg;
    logic             changed_next;

    // Per-bit next-state selection: clear, then load, then hold.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_next
            assign q_next[gi] = clr ? CLEAR_VAL[gi] : (en ? d[gi] : q_reg[gi]);
        end
    endgenerate

    // The flag is raised only when the stored value is actually about to differ.
    assign changed_next = |(q_next ^ q_reg);

    // State register; reset takes effect immediately and wins over any capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg       <= RESET_VAL;
            changed_reg <= 1'b0;
        end else begin
            q_reg       <= q_next;
            changed_reg <= changed_next;
        end
    end

    assign q       = q_reg;
    assign qn      = ~q_reg;
    assign changed = changed_reg;

endmodule

// File: tb/tb_d_ff.sv
// Directed testbench for d_ff.
// It uses three instances: a 1-bit register, an 8-bit register, and a 4-bit register with non-zero reset and clear values.
module tb_d_ff;

    logic clk;
    int   vectors;
    int   miscompares;

    // WIDTH=1 instance
    logic rst_n1, d1, en1, clr1, q1, qn1, changed1;
    // WIDTH=8 instance
    logic       rst_n8, en8, clr8, changed8;
    logic [7:0] d8, q8, qn8;
    // WIDTH=4, RESET_VAL=F, CLEAR_VAL=3 instance
    logic       rst_n4, en4, clr4, changed4;
    logic [3:0] d4, q4, qn4;

    d_ff #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n1), .d(d1), .en(en1), .clr(clr1),
        .q(q1), .qn(qn1), .changed(changed1)
    );

    d_ff #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n8), .d(d8), .en(en8), .clr(clr8),
        .q(q8), .qn(qn8), .changed(changed8)
    );

    d_ff #(.WIDTH(4), .RESET_VAL(4'hF), .CLEAR_VAL(4'h3)) dut4 (
        .clk(clk), .rst_n(rst_n4), .d(d4), .en(en4), .clr(clr4),
        .q(q4), .qn(qn4), .changed(changed4)
    );

    // 20 ns period, rising edges at 10, 30, 50, ...
    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic test_reset;
        d1 = 1'b1;
        en1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (q1 !== 1'b0 || qn1 !== 1'b1 || changed1 !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_hold[%0d]: q=%b qn=%b changed=%b, required q=0 qn=1 changed=0", i, q1, qn1, changed1);
            end
        end
        @(negedge clk);
        rst_n1 = 1'b1;
        #1;
        vectors++;
        if (q1 !== 1'b0 || changed1 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release_no_edge: q=%b changed=%b, required q=0 changed=0", q1, changed1);
        end
        @(posedge clk); #1;
        vectors++;
        if (q1 !== 1'b1 || changed1 !== 1'b1) begin
            miscompares++;
            $display("FAIL first_capture: q=%b changed=%b, required q=1 changed=1", q1, changed1);
        end
        $display("test_reset done");
    endtask

    task automatic test_basic_capture;
        @(negedge clk);
        d1 = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (q1 !== 1'b0 || qn1 !== 1'b1 || changed1 !== 1'b1) begin
            miscompares++;
            $display("FAIL capture_0: q=%b qn=%b changed=%b, required q=0 qn=1 changed=1", q1, qn1, changed1);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (q1 !== 1'b0 || changed1 !== 1'b0) begin
                miscompares++;
                $display("FAIL steady_0[%0d]: q=%b changed=%b, required q=0 changed=0", i, q1, changed1);
            end
        end
        @(negedge clk);
        d1 = 1'b1;
        #1;
        vectors++;
        if (q1 !== 1'b0) begin
            miscompares++;
            $display("FAIL no_comb_path: q=%b, required q=0", q1);
        end
        @(posedge clk); #1;
        vectors++;
        if (q1 !== 1'b1 || qn1 !== 1'b0 || changed1 !== 1'b1) begin
            miscompares++;
            $display("FAIL capture_1: q=%b qn=%b changed=%b, required q=1 qn=0 changed=1", q1, qn1, changed1);
        end
        @(posedge clk); #1;
        vectors++;
        if (q1 !== 1'b1 || changed1 !== 1'b0) begin
            miscompares++;
            $display("FAIL changed_one_cycle: q=%b changed=%b, required q=1 changed=0", q1, changed1);
        end
        $display("test_basic_capture done");
    endtask

    task automatic test_enable_hold;
        @(negedge clk);
        en1 = 1'b0;
        d1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (q1 !== 1'b1 || changed1 !== 1'b0) begin
                miscompares++;
                $display("FAIL enable_hold[%0d]: q=%b changed=%b, required q=1 changed=0", i, q1, changed1);
            end
        end
        @(negedge clk);
        en1 = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (q1 !== 1'b0 || changed1 !== 1'b1) begin
            miscompares++;
            $display("FAIL enable_load: q=%b changed=%b, required q=0 changed=1", q1, changed1);
        end
        $display("test_enable_hold done");
    endtask

    task automatic test_sync_clear;
        @(negedge clk);
        d1 = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (q1 !== 1'b1) begin
            miscompares++;
            $display("FAIL clear_setup: q=%b, required q=1", q1);
        end
        @(negedge clk);
        clr1 = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (q1 !== 1'b0 || changed1 !== 1'b1) begin
            miscompares++;
            $display("FAIL clear_over_enable: q=%b changed=%b, required q=0 changed=1", q1, changed1);
        end
        @(negedge clk);
        clr1 = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (q1 !== 1'b1 || changed1 !== 1'b1) begin
            miscompares++;
            $display("FAIL clear_release: q=%b changed=%b, required q=1 changed=1", q1, changed1);
        end
        @(negedge clk);
        en1 = 1'b0;
        clr1 = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (q1 !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_without_enable: q=%b, required q=0", q1);
        end
        @(negedge clk);
        clr1 = 1'b0;
        $display("test_sync_clear done");
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        rst_n8 = 1'b1;
        en8 = 1'b1;
        d8 = 8'hA5;
        @(posedge clk); #1;
        vectors++;
        if (q8 !== 8'hA5 || qn8 !== 8'h5A || changed8 !== 1'b1) begin
            miscompares++;
            $display("FAIL load_a5: q=%h qn=%h changed=%b, required q=a5 qn=5a changed=1", q8, qn8, changed8);
        end
        #4;
        rst_n8 = 1'b0;
        #1;
        vectors++;
        if (q8 !== 8'h00 || qn8 !== 8'hFF || changed8 !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset_mid_cycle: q=%h qn=%h changed=%b, required q=00 qn=ff changed=0", q8, qn8, changed8);
        end
        @(negedge clk);
        rst_n8 = 1'b1;
        d8 = 8'h3C;
        @(posedge clk); #1;
        vectors++;
        if (q8 !== 8'h3C) begin
            miscompares++;
            $display("FAIL reload_3c: q=%h, required q=3c", q8);
        end
        @(negedge clk);
        d8 = 8'hFF;
        @(posedge clk);
        rst_n8 = 1'b0;
        #1;
        vectors++;
        if (q8 !== 8'h00 || changed8 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_at_edge: q=%h changed=%b, required q=00 changed=0", q8, changed8);
        end
        $display("test_async_reset done");
    endtask

    task automatic test_params;
        vectors++;
        if (q4 !== 4'hF || qn4 !== 4'h0 || changed4 !== 1'b0) begin
            miscompares++;
            $display("FAIL param_reset: q=%h qn=%h changed=%b, required q=f qn=0 changed=0", q4, qn4, changed4);
        end
        @(negedge clk);
        rst_n4 = 1'b1;
        clr4 = 1'b1;
        en4 = 1'b1;
        d4 = 4'h7;
        @(posedge clk); #1;
        vectors++;
        if (q4 !== 4'h3 || qn4 !== 4'hC || changed4 !== 1'b1) begin
            miscompares++;
            $display("FAIL param_clear: q=%h qn=%h changed=%b, required q=3 qn=c changed=1", q4, qn4, changed4);
        end
        @(posedge clk); #1;
        vectors++;
        if (q4 !== 4'h3 || changed4 !== 1'b0) begin
            miscompares++;
            $display("FAIL param_clear_again: q=%h changed=%b, required q=3 changed=0", q4, changed4);
        end
        @(negedge clk);
        clr4 = 1'b0;
        d4 = 4'h9;
        @(posedge clk); #1;
        vectors++;
        if (q4 !== 4'h9 || qn4 !== 4'h6 || changed4 !== 1'b1) begin
            miscompares++;
            $display("FAIL param_load_9: q=%h qn=%h changed=%b, required q=9 qn=6 changed=1", q4, qn4, changed4);
        end
        @(posedge clk); #1;
        vectors++;
        if (q4 !== 4'h9 || changed4 !== 1'b0) begin
            miscompares++;
            $display("FAIL param_same_value: q=%h changed=%b, required q=9 changed=0", q4, changed4);
        end
        @(negedge clk);
        en4 = 1'b0;
        d4 = 4'h0;
        @(posedge clk); #1;
        vectors++;
        if (q4 !== 4'h9 || changed4 !== 1'b0) begin
            miscompares++;
            $display("FAIL param_hold: q=%h changed=%b, required q=9 changed=0", q4, changed4);
        end
        $display("test_params done");
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n1 = 1'b0; d1 = 1'b0; en1 = 1'b0; clr1 = 1'b0;
        rst_n8 = 1'b0; d8 = 8'h00; en8 = 1'b0; clr8 = 1'b0;
        rst_n4 = 1'b0; d4 = 4'h0; en4 = 1'b0; clr4 = 1'b0;

        test_reset();
        test_basic_capture();
        test_enable_hold();
        test_sync_clear();
        test_async_reset();
        test_params();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/d_ff.md
Name: d_ff

Overview:
- Parameterizable D-type register with asynchronous active-low reset.
- Optional synchronous clear, load enable and complementary output.
- Basic storage primitive for pipeline/state registers across the design.
- With WIDTH=1 and en tied high it behaves as a single positive-edge D flip-flop: q follows d one clock edge later.

Parameters:
- WIDTH, 1, number of stored bits in d/q/qn.
- RESET_VAL, {WIDTH{1'b0}}, value loaded into q on asynchronous reset.
- CLEAR_VAL, {WIDTH{1'b0}}, value loaded into q on synchronous clear.

Ports:
- clk  input  1  clock; all synchronous activity on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- d  input  WIDTH  data input.
- en  input  1  load enable; q captures d only when high.
- clr  input  1  synchronous clear, active high.
- q  output  WIDTH  registered data.
- qn  output  WIDTH  bitwise complement of q.
- changed  output  1  registered flag, high for one cycle after any edge where q took a different value.

Interface: one clock; reset is asynchronous and active-low (clk, rst_n).

Behaviour:
- rst_n low: q = RESET_VAL and changed = 0 immediately, independent of clk. Held while rst_n is low.
- rst_n deassertion is not synchronized inside the block. The reset synchronizer is the integrator's responsibility.
- First capture occurs at the first rising clk edge with rst_n high.
- Rising clk edge, rst_n high, priority order:
  1. clr=1 → q <= CLEAR_VAL, regardless of en and d.
  2. else en=1 → q <= d.
  3. else q holds.
- Latency: exactly one clock edge from d to q. No combinational path from d to q.
- qn = ~q, purely combinational from the register, valid in reset (~RESET_VAL).
- changed <= (next q != current q), evaluated at each rising edge. It is 0 on any hold cycle and when the loaded value equals the current value.
- d sampled at the rising edge only. Glitches between edges have no effect.
- Reset asserted mid-cycle overrides any pending capture. Reset asserted coincident with a clk edge: reset wins.
- No X propagation beyond d: if d is X and en=1, q may become X. Reset always restores a known value.
- Width rule: all data ports are exactly WIDTH bits. No extension or truncation inside the block.

Test Plan:
- Reset: rst_n=0 with clk toggling, d=1 → q=0, qn=1, changed=0 throughout. Release rst_n and q stays 0 until the next rising edge.
- Basic capture (WIDTH=1, en=1, clr=0, 20 ns clock period):
  - d=0 for 100 ns → q=0.
  - d=1 at 100 ns → q=1 at the first rising edge after 100 ns (110 ns), and qn=0.
  - changed pulses exactly one cycle.
- Enable hold: q=1, en=0, d=0 for 3 edges → q stays 1 and changed=0. Then en=1 → q=0 on the next edge.
- Sync clear priority: q=1, en=1, d=1, clr=1 → q=0 at the next edge. Set clr=0 → q=1 on the following edge.
- Async reset mid-operation: WIDTH=8, q=8'hA5, drop rst_n between edges → q=RESET_VAL immediately, without waiting for clk.
- Parameter check: WIDTH=4, RESET_VAL=4'hF, CLEAR_VAL=4'h3:
  - Reset → q=4'hF, qn=4'h0.
  - clr → q=4'h3.
  - d=4'h9 with en → q=4'h9.
